fb_muldiv: RTL and testbench
============================

# fb_muldiv

Iterative RV32M execution unit for the Firebird pipeline, parametrised by datapath width. It accepts one-hot M-extension op selects from the ALU control decoder, in the same bit order the decoder emits them. Integer multiply and divide are computed over multiple cycles behind a valid/ready handshake, and the EX stage stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, default 32: operand/result width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `op_m`  in  8  one-hot, bits 7..0 = {mul, mulh, mulhsu, mulhu, div, divu, rem, remu}.
- `rs1`  in  XLEN  operand A (multiplicand/dividend).
- `rs2`  in  XLEN  operand B (multiplier/divisor).
- `flush`  in  1  synchronous kill of the in-flight op.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  product low/high half, quotient or remainder.

## Operation
- States: IDLE, CALC, DONE.
- IDLE→CALC on `in_valid && in_ready && !flush`.
  - Latches the op, |rs1| and |rs2| per signedness, and sign flags.
  - Clears the counter.
- Fast entry IDLE→DONE, skipping CALC. The result is written directly in the following cases:
  - Divisor == 0:
    - div/divu → all ones.
    - rem/remu → rs1.
  - Signed overflow (rs1 == 1<<(XLEN-1), rs2 == all ones):
    - div → rs1.
    - rem → 0.
  - `op_m` not exactly one-hot → 0.
- CALC runs for exactly XLEN cycles, with counter 0..XLEN-1, then goes to DONE.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
- Signedness of operands:
  - mul, mulh, div, rem: rs1 and rs2 signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu, divu, remu: both unsigned.
- Final sign fix:
  - Product is negated (2·XLEN) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result select:
  - mul → product[XLEN-1:0].
  - mulh/mulhsu/mulhu → product[2XLEN-1:XLEN].
- DONE: `out_valid` = 1 and `result` is held stable until `out_ready`, then the unit returns to IDLE.
- `flush` from any state → IDLE on the next edge.
  - `out_valid` drops.
  - No result is produced.
  - `flush` has priority over accept and over `out_ready`.
- No back-to-back issue: `in_ready` is low in CALC and DONE.

## Timing
- Reset (async, `rst_n` low) drives:
  - state = IDLE, counter = 0.
  - `out_valid` = 0, `result` = 0, `in_ready` = 1.
  - Internal accumulators = 0.
- Reset mid-CALC or mid-DONE aborts immediately. The first accept is possible on the first edge after release.
- `in_ready` and `out_valid` are decoded from registered state only (no combinational input→output path).
- Iterative latency: accept at edge k; CALC occupies cycles k+1..k+XLEN; `out_valid` is high from edge k+XLEN+1.
  - XLEN=32 → 33 cycles.
- Fast-entry latency: `out_valid` is high from edge k+1.
- Minimum issue interval equals latency + 1 (a DONE cycle with `out_ready` = 1 is followed by IDLE).
- Counter width is $clog2(XLEN)+1. It never wraps; CALC exit is at count == XLEN-1.

## Configuration
- `FB_MULDIV_SINGLE_CYCLE_MUL_EN`
  - Defined: mul/mulh/mulhsu/mulhu compute the full 2·XLEN signed/unsigned product combinationally in the accept cycle and take fast entry to DONE (latency 1). Divide is unchanged.
  - Undefined: all multiplies use the XLEN-cycle iterative path, and no XLEN×XLEN multiplier is synthesised.

## Test plan
All scenarios use XLEN=32 with the macro undefined unless stated.
- mul rs1=7, rs2=0xFFFFFFFD → `result` 0xFFFFFFEB; `out_valid` first high 33 cycles after accept.
- mulh 0x80000000×0x80000000 → 0x40000000.
- mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- div 0xFFFFFFF9/2 → 0xFFFFFFFD.
- rem 0xFFFFFFF9/2 → 0xFFFFFFFF.
- divu 100/7 → 14.
- remu 100/7 → 2.
- divu 5/0 → 0xFFFFFFFF.
- remu 5/0 → 5.
- div 0x80000000/0xFFFFFFFF → 0x80000000.
- rem 0x80000000/0xFFFFFFFF → 0.
- The three zero-divisor/overflow cases above each complete with `out_valid` one cycle after accept.
- Hold `out_ready` = 0 for 3 cycles in DONE → `result` stable and `in_ready` = 0; release → IDLE next edge.
- `flush` 10 cycles into CALC → IDLE next edge with no `out_valid`; next mul 3×4 returns 12.
- `rst_n` low mid-CALC → `out_valid` 0 and `in_ready` 1 immediately.
- With macro defined: mul 3×4 returns 12 at latency 1.

Source files
------------

// File: rtl/fb_muldiv.sv
// ============================================================================
// Module   : fb_muldiv
// Purpose  : Iterative RV32M multiply/divide unit with a valid/ready handshake.
//            Define FB_MULDIV_SINGLE_CYCLE_MUL_EN to make multiplies single-cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fb_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [7:0]      op_m,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic                  mul_q, hi_q, rem_q, neg_q;
   logic [XLEN-1:0]       opnd_q;
   logic [2*XLEN-1:0]     acc_q;
   logic [XLEN-1:0]       result_q;

   logic                  w_is_mul, w_is_div, w_s1, w_s2, w_neg1, w_neg2;
   logic [XLEN-1:0]       w_abs1, w_abs2;
   logic                  w_onehot, w_dz, w_ovf, w_fast;
   logic [XLEN-1:0]       w_fast_res;

   assign w_is_mul = |op_m[7:4];
   assign w_is_div = |op_m[3:0];
   assign w_s1     = op_m[7] | op_m[6] | op_m[5] | op_m[3] | op_m[1];
   assign w_s2     = op_m[7] | op_m[6] | op_m[3] | op_m[1];
   assign w_neg1   = w_s1 & rs1[XLEN-1];
   assign w_neg2   = w_s2 & rs2[XLEN-1];
   assign w_abs1   = w_neg1 ? -rs1 : rs1;
   assign w_abs2   = w_neg2 ? -rs2 : rs2;
   assign w_onehot = (op_m != 8'd0) && ((op_m & (op_m - 8'd1)) == 8'd0);
   assign w_dz     = (rs2 == '0);
   assign w_ovf    = (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

`ifdef FB_MULDIV_SINGLE_CYCLE_MUL_EN
   logic [2*XLEN+1:0] w_op1, w_op2, w_prod;
   assign w_op1  = {{(XLEN+2){w_neg1 ? 1'b1 : 1'b0}}, rs1};
   assign w_op2  = {{(XLEN+2){w_neg2 ? 1'b1 : 1'b0}}, rs2};
   assign w_prod = w_op1 * w_op2;
`endif

   // Operations whose result is known in the accept cycle bypass CALC.
   always_comb begin
      w_fast     = 1'b1;
      w_fast_res = '0;
      if (!w_onehot) begin
         w_fast_res = '0;
      end else if (w_is_div && w_dz) begin
         w_fast_res = (op_m[3] | op_m[2]) ? '1 : rs1;
      end else if ((op_m[3] | op_m[1]) && w_ovf) begin
         w_fast_res = op_m[3] ? rs1 : '0;
`ifdef FB_MULDIV_SINGLE_CYCLE_MUL_EN
      end else if (w_is_mul) begin
         w_fast_res = op_m[7] ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`endif
      end else begin
         w_fast = 1'b0;
      end
   end

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_step, w_step_neg;
   logic [XLEN:0]       w_div_r;
   logic [XLEN+1:0]     w_div_diff;
   logic                w_div_ok;
   logic [XLEN-1:0]     w_rem_neg, w_final;

   assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
   assign w_div_r    = acc_q[2*XLEN-1:XLEN-1];
   assign w_div_diff = {1'b0, w_div_r} - {2'b00, opnd_q};
   assign w_div_ok   = ~w_div_diff[XLEN+1];
   assign w_div_next = {(w_div_ok ? w_div_diff[XLEN-1:0] : w_div_r[XLEN-1:0]),
                        acc_q[XLEN-2:0], w_div_ok};
   assign w_step     = mul_q ? w_mul_next : w_div_next;
   assign w_step_neg = -w_step;
   assign w_rem_neg  = -w_step[2*XLEN-1:XLEN];

   always_comb begin
      w_final = '0;
      if (mul_q) begin
         if (hi_q) w_final = neg_q ? w_step_neg[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
         else      w_final = neg_q ? w_step_neg[XLEN-1:0]      : w_step[XLEN-1:0];
      end else if (rem_q) begin
         w_final = neg_q ? w_rem_neg : w_step[2*XLEN-1:XLEN];
      end else begin
         w_final = neg_q ? w_step_neg[XLEN-1:0] : w_step[XLEN-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mul_q    <= 1'b0;
         hi_q     <= 1'b0;
         rem_q    <= 1'b0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  cnt_q  <= '0;
                  mul_q  <= w_is_mul;
                  hi_q   <= ~op_m[7];
                  rem_q  <= op_m[1] | op_m[0];
                  neg_q  <= (op_m[1] | op_m[0]) ? w_neg1 : (w_neg1 ^ w_neg2);
                  opnd_q <= w_is_mul ? w_abs1 : w_abs2;
                  acc_q  <= {{XLEN{1'b0}}, (w_is_mul ? w_abs2 : w_abs1)};
                  if (w_fast) begin
                     result_q <= w_fast_res;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= w_step;
               if (cnt_q == CW'(XLEN-1)) begin
                  result_q <= w_final;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_muldiv.sv
// ============================================================================
// Module   : tb_fb_muldiv
// Purpose  : Directed vector bench for fb_muldiv at XLEN=32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fb_muldiv;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
   logic [7:0]  op_m;
   logic [31:0] rs1, rs2, result;

   fb_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_m(op_m), .rs1(rs1), .rs2(rs2), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   always #5 clk = ~clk;

`ifdef FB_MULDIV_SINGLE_CYCLE_MUL_EN
   localparam int LM = 1;
`else
   localparam int LM = 33;
`endif

   localparam logic [7:0] MUL = 8'h80, MULH = 8'h40, MULHSU = 8'h20, MULHU = 8'h10;
   localparam logic [7:0] DIV = 8'h08, DIVU = 8'h04, REM = 8'h02, REMU = 8'h01;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[15];
   int   nchk = 0;
   int   nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_m = op; rs1 = a; rs2 = b; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      issue(op, a, b);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = result;
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          seen;

      vt[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LM};
      vt[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, LM};
      vt[2]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LM};
      vt[3]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LM};
      vt[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
      vt[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
      vt[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       33};
      vt[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        33};
      vt[8]  = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vt[9]  = '{REMU,   32'd5,        32'd0,        32'd5,        1};
      vt[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vt[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      vt[12] = '{8'h03,  32'd9,        32'd3,        32'd0,        1};
      vt[13] = '{MUL,    32'h00012345, 32'h00001000, 32'h12345000, LM};
      vt[14] = '{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      op_m = '0; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready},  32'd1);
      chk("rst_result", result, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, res, lat);
         chk($sformatf("v%0d_result", i), res, vt[i].exp);
         chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
         drain($sformatf("v%0d", i));
      end

      // Backpressure in DONE.
      run_op(MUL, 32'd5, 32'd6, res, lat);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_result", result, 32'd30);
         chk("hold_inready", {31'd0, in_ready}, 32'd0);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_ready", {31'd0, in_ready}, 32'd1);
      chk("release_valid", {31'd0, out_valid}, 32'd0);

      // Flush mid-CALC.
      issue(DIVU, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      chk("flush_busy", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("flush_noresult", seen, 32'd0);
      run_op(MUL, 32'd3, 32'd4, res, lat);
      chk("post_flush_mul", res, 32'd12);
      chk("post_flush_lat", lat, LM);
      drain("post_flush");

      // Async reset mid-CALC.
      issue(DIVU, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(REMU, 32'd100, 32'd7, res, lat);
      chk("post_rst_remu", res, 32'd2);
      chk("post_rst_lat", lat, 33);
      drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
